// File: rtl/intel_vvp_icon_pkg.sv
// Shared VVP/ICON definitions: packet type codes, field widths, IP word layout and helpers.
package intel_vvp_icon_pkg;

    localparam int VVP_CTRL_TYPE_W = 5;
    localparam logic [VVP_CTRL_TYPE_W-1:0] VVP_CTRL_PKT_IP  = 5'd0;
    localparam logic [VVP_CTRL_TYPE_W-1:0] VVP_CTRL_PKT_EOF = 5'd1;

    localparam int VVP_COLSPACE_W    = 7;
    localparam int VVP_BPS_W         = 5;
    localparam int VVP_INTERLACE_W   = 4;
    localparam int VVP_COSITING_W    = 2;
    localparam int VVP_SUBSAMPLING_W = 2;

    // Image-Info packet layout: five 16b words, least significant word first
    localparam int VVP_CTRL_IP_WORDS    = 5;
    localparam int VVP_IP_WORD_TYPE     = 0;
    localparam int VVP_IP_WORD_WIDTH    = 1;
    localparam int VVP_IP_WORD_HEIGHT   = 2;
    localparam int VVP_IP_WORD_FORMAT   = 3;
    localparam int VVP_IP_WORD_SAMPLING = 4;

    // Field positions inside the format and sampling words
    localparam int VVP_FMT_INTERLACE_LSB   = 0;
    localparam int VVP_FMT_BPS_LSB         = 4;
    localparam int VVP_FMT_COLSPACE_LSB    = 9;
    localparam int VVP_SMP_SUBSAMPLING_LSB = 0;
    localparam int VVP_SMP_COSITING_LSB    = 2;

    typedef enum logic [1:0] {
        VVP_ST_IDLE,
        VVP_ST_SEND_IP,
        VVP_ST_IN_FRAME,
        VVP_ST_SEND_EOF
    } vvp_ctrl_state_e;

    function automatic int vvp_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic [15:0] vvp_ctrl_fmt_word(
        input logic [VVP_COLSPACE_W-1:0]  colspace,
        input logic [VVP_BPS_W-1:0]       bps,
        input logic [VVP_INTERLACE_W-1:0] interlace
    );
        return {colspace, bps, interlace};
    endfunction

    function automatic logic [15:0] vvp_ctrl_smp_word(
        input logic [VVP_COSITING_W-1:0]    cositing,
        input logic [VVP_SUBSAMPLING_W-1:0] subsampling
    );
        return {12'b0, cositing, subsampling};
    endfunction

    // Word idx of an IP packet; indices past the last word read as zero padding
    function automatic logic [15:0] vvp_ctrl_ip_word(
        input int          idx,
        input logic [15:0] w,
        input logic [15:0] h,
        input logic [15:0] fmt,
        input logic [15:0] smp
    );
        logic [15:0] word;
        case (idx)
            VVP_IP_WORD_TYPE:     word = {11'b0, VVP_CTRL_PKT_IP};
            VVP_IP_WORD_WIDTH:    word = w;
            VVP_IP_WORD_HEIGHT:   word = h;
            VVP_IP_WORD_FORMAT:   word = fmt;
            VVP_IP_WORD_SAMPLING: word = smp;
            default:              word = 16'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/intel_vvp_icon_ctrl_word_packer.sv
// Combinational packer: maps the current beat index onto a TDATA_W-wide slice of control words.
module intel_vvp_icon_ctrl_word_packer
    import intel_vvp_icon_pkg::*;
#(
    parameter int          WPB      = 2,
    parameter int          BEAT_W   = 1,
    parameter logic [15:0] FMT_WORD = 16'd0,
    parameter logic [15:0] SMP_WORD = 16'd0
) (
    input  logic [BEAT_W-1:0]  beat_i,
    input  logic               ip_sel_i,
    input  logic               eof_sel_i,
    input  logic [15:0]        width_i,
    input  logic [15:0]        height_i,
    output logic [16*WPB-1:0]  tdata_o
);

    // Bus idles at zero; EOF carries only its type word, IP beats carry WPB consecutive words
    always_comb begin
        tdata_o = '0;
        if (eof_sel_i) begin
            tdata_o[15:0] = {11'b0, VVP_CTRL_PKT_EOF};
        end else if (ip_sel_i) begin
            for (int k = 0; k < WPB; k++) begin
                tdata_o[16*k +: 16] = vvp_ctrl_ip_word(int'(beat_i) * WPB + k,
                                                       width_i, height_i, FMT_WORD, SMP_WORD);
            end
        end
    end

endmodule

// File: rtl/intel_vvp_icon_ctrl_pkt_gen.sv
// VVP full-mode control packet generator: one IP packet per frame request, one EOF packet per EOF request.
module intel_vvp_icon_ctrl_pkt_gen
    import intel_vvp_icon_pkg::*;
#(
    parameter int                          PIXELS_IN_PARALLEL = 1,
    parameter int                          NUM_COLOUR_PLANES  = 3,
    parameter int                          BPS                = 10,
    parameter logic [VVP_COLSPACE_W-1:0]    COLSPACE           = 7'd0,
    parameter logic [VVP_SUBSAMPLING_W-1:0] SUBSAMPLING        = 2'b11,
    parameter logic [VVP_COSITING_W-1:0]    COSITING           = 2'b00,
    parameter logic [VVP_INTERLACE_W-1:0]   INTERLACE          = 4'b0011,
    parameter int                          MAX_WIDTH          = 4096,
    parameter int                          MAX_HEIGHT         = 2160,
    localparam int DATA_BITS = PIXELS_IN_PARALLEL * NUM_COLOUR_PLANES * BPS,
    localparam int WPB       = ((DATA_BITS + 15) / 16 < 1) ? 1 : (DATA_BITS + 15) / 16,
    localparam int TDATA_W   = 16 * WPB
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        cfg_width,
    input  logic [15:0]        cfg_height,
    input  logic               frame_req_valid,
    output logic               frame_req_ready,
    input  logic               eof_req_valid,
    output logic               eof_req_ready,
    output logic [TDATA_W-1:0] ctrl_tdata,
    output logic               ctrl_tvalid,
    input  logic               ctrl_tready,
    output logic               ctrl_tlast,
    output logic               ctrl_tuser
);

    localparam int IP_BEATS = (VVP_CTRL_IP_WORDS + WPB - 1) / WPB;
    localparam int BEAT_W   = (vvp_clog2(IP_BEATS) < 1) ? 1 : vvp_clog2(IP_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IP_BEATS - 1);
    localparam logic [15:0] FMT_WORD = vvp_ctrl_fmt_word(COLSPACE, VVP_BPS_W'(BPS), INTERLACE);
    localparam logic [15:0] SMP_WORD = vvp_ctrl_smp_word(COSITING, SUBSAMPLING);
    localparam logic [15:0] WIDTH_LIMIT  = 16'(MAX_WIDTH);
    localparam logic [15:0] HEIGHT_LIMIT = 16'(MAX_HEIGHT);

    vvp_ctrl_state_e   state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic              ip_sel, eof_sel;

    // State, beat counter and the frame size captured at request acceptance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= VVP_ST_IDLE;
            beat_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

    // Next-state and handshake decode; readies and tvalid come from state only, never from a valid input
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        width_d         = width_q;
        height_d        = height_q;
        frame_req_ready = 1'b0;
        eof_req_ready   = 1'b0;
        ip_sel          = 1'b0;
        eof_sel         = 1'b0;
        ctrl_tlast      = 1'b0;
        unique case (state_q)
            VVP_ST_IDLE: begin
                frame_req_ready = 1'b1;
                if (frame_req_valid) begin
                    state_d  = VVP_ST_SEND_IP;
                    beat_d   = '0;
                    width_d  = (cfg_width  > WIDTH_LIMIT)  ? WIDTH_LIMIT  : cfg_width;
                    height_d = (cfg_height > HEIGHT_LIMIT) ? HEIGHT_LIMIT : cfg_height;
                end
            end
            VVP_ST_SEND_IP: begin
                ip_sel     = 1'b1;
                ctrl_tlast = (beat_q == LAST_BEAT);
                if (ctrl_tready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = VVP_ST_IN_FRAME;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            VVP_ST_IN_FRAME: begin
                eof_req_ready = 1'b1;
                if (eof_req_valid) begin
                    state_d = VVP_ST_SEND_EOF;
                end
            end
            VVP_ST_SEND_EOF: begin
                eof_sel    = 1'b1;
                ctrl_tlast = 1'b1;
                if (ctrl_tready) begin
                    state_d = VVP_ST_IDLE;
                end
            end
            default: begin
                state_d = VVP_ST_IDLE;
            end
        endcase
        ctrl_tvalid = ip_sel | eof_sel;
        ctrl_tuser  = ip_sel | eof_sel;
    end

    intel_vvp_icon_ctrl_word_packer #(
        .WPB      (WPB),
        .BEAT_W   (BEAT_W),
        .FMT_WORD (FMT_WORD),
        .SMP_WORD (SMP_WORD)
    ) u_packer (
        .beat_i    (beat_q),
        .ip_sel_i  (ip_sel),
        .eof_sel_i (eof_sel),
        .width_i   (width_q),
        .height_i  (height_q),
        .tdata_o   (ctrl_tdata)
    );

endmodule

// File: tb/tb_intel_vvp_icon_ctrl_pkt_gen.sv
// Bench for the control packet generator: default instance plus a wide (single-beat IP) instance.
module tb_intel_vvp_icon_ctrl_pkt_gen;

    function automatic int wordsPerBeat(input int pip, input int ncp, input int bps);
        int n;
        n = (pip * ncp * bps + 15) / 16;
        return (n < 1) ? 1 : n;
    endfunction

    localparam int A_BPS = 10;
    localparam int B_BPS = 12;
    localparam int A_WPB = wordsPerBeat(1, 3, A_BPS);
    localparam int B_WPB = wordsPerBeat(4, 3, B_BPS);
    localparam int A_W   = 16 * A_WPB;
    localparam int B_W   = 16 * B_WPB;
    localparam int MAX_W = 4096;
    localparam int MAX_H = 2160;
    localparam int COLSPACE_V    = 0;
    localparam int INTERLACE_V   = 3;
    localparam int COSITING_V    = 0;
    localparam int SUBSAMPLING_V = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [15:0] cfgWidth = '0;
    logic [15:0] cfgHeight = '0;
    logic ctrlTready = 1'b0;

    logic aFrameValid = 1'b0, aEofValid = 1'b0;
    logic aFrameReady, aEofReady, aValid, aLast, aUser;
    logic [A_W-1:0] aData;
    logic bFrameValid = 1'b0, bEofValid = 1'b0;
    logic bFrameReady, bEofReady, bValid, bLast, bUser;
    logic [B_W-1:0] bData;

    bit useB = 1'b0;
    logic [159:0] obsData;
    logic obsValid, obsLast, obsUser, obsFrameReady, obsEofReady;

    int nCompared = 0;
    int nMismatched = 0;
    logic [159:0] expQ[$];
    bit lastQ[$];

    always #5 clock = ~clock;

    intel_vvp_icon_ctrl_pkt_gen dutA (
        .clock (clock), .reset (reset),
        .cfg_width (cfgWidth), .cfg_height (cfgHeight),
        .frame_req_valid (aFrameValid), .frame_req_ready (aFrameReady),
        .eof_req_valid (aEofValid), .eof_req_ready (aEofReady),
        .ctrl_tdata (aData), .ctrl_tvalid (aValid), .ctrl_tready (ctrlTready),
        .ctrl_tlast (aLast), .ctrl_tuser (aUser)
    );

    intel_vvp_icon_ctrl_pkt_gen #(
        .PIXELS_IN_PARALLEL (4), .NUM_COLOUR_PLANES (3), .BPS (B_BPS)
    ) dutB (
        .clock (clock), .reset (reset),
        .cfg_width (cfgWidth), .cfg_height (cfgHeight),
        .frame_req_valid (bFrameValid), .frame_req_ready (bFrameReady),
        .eof_req_valid (bEofValid), .eof_req_ready (bEofReady),
        .ctrl_tdata (bData), .ctrl_tvalid (bValid), .ctrl_tready (ctrlTready),
        .ctrl_tlast (bLast), .ctrl_tuser (bUser)
    );

    // Observation mux so one set of checking tasks serves both instances
    always_comb begin
        obsData       = useB ? 160'(bData) : 160'(aData);
        obsValid      = useB ? bValid : aValid;
        obsLast       = useB ? bLast : aLast;
        obsUser       = useB ? bUser : aUser;
        obsFrameReady = useB ? bFrameReady : aFrameReady;
        obsEofReady   = useB ? bEofReady : aEofReady;
    end

    task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference IP packet: five words from the field rules, laid out wpb words per beat, LSW first
    function automatic void loadIpPacket(input int w, input int h, input int wpb, input int bps);
        logic [15:0] words[5];
        int nBeats;
        words[0] = 16'd0;
        words[1] = 16'((w > MAX_W) ? MAX_W : w);
        words[2] = 16'((h > MAX_H) ? MAX_H : h);
        words[3] = 16'(COLSPACE_V * 512 + bps * 16 + INTERLACE_V);
        words[4] = 16'(COSITING_V * 4 + SUBSAMPLING_V);
        nBeats = (5 + wpb - 1) / wpb;
        for (int b = 0; b < nBeats; b++) begin
            logic [159:0] beat;
            beat = '0;
            for (int k = 0; k < wpb; k++) begin
                if (b * wpb + k < 5) beat[16*k +: 16] = words[b * wpb + k];
            end
            expQ.push_back(beat);
            lastQ.push_back(b == nBeats - 1);
        end
    endfunction

    function automatic void loadEofPacket();
        expQ.push_back(160'd1);
        lastQ.push_back(1'b1);
    endfunction

    // Raise a request at a negedge, wait for ready, drop it after the accepting edge
    task automatic applyStimulus(input bit isEof, input int w, input int h);
        int budget;
        budget = 50;
        cfgWidth = 16'(w);
        cfgHeight = 16'(h);
        if (useB) begin
            if (isEof) bEofValid = 1'b1; else bFrameValid = 1'b1;
        end else begin
            if (isEof) aEofValid = 1'b1; else aFrameValid = 1'b1;
        end
        while (!(isEof ? obsEofReady : obsFrameReady) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        checkOutput("req_accept_in_budget", 160'(budget > 0), 160'(1));
        @(negedge clock);
        if (useB) begin
            if (isEof) bEofValid = 1'b0; else bFrameValid = 1'b0;
        end else begin
            if (isEof) aEofValid = 1'b0; else aFrameValid = 1'b0;
        end
        cfgWidth = 16'($urandom);
        cfgHeight = 16'($urandom);
        checkOutput("latency_tvalid", 160'(obsValid), 160'(1));
    endtask

    // Consume the expected beats; mode 0 = always ready, 1 = ready 1010..., 2 = random ready
    task automatic drainPacket(input string tag, input int mode);
        int budget;
        int cyc;
        budget = 200;
        cyc = 0;
        while (expQ.size() > 0 && budget > 0) begin
            case (mode)
                0:       ctrlTready = 1'b1;
                1:       ctrlTready = (cyc % 2 == 0);
                default: ctrlTready = 1'($urandom_range(0, 1));
            endcase
            checkOutput({tag, "_tvalid"}, 160'(obsValid), 160'(1));
            checkOutput({tag, "_tdata"}, obsData, expQ[0]);
            checkOutput({tag, "_tlast"}, 160'(obsLast), 160'(lastQ[0]));
            checkOutput({tag, "_tuser"}, 160'(obsUser), 160'(1));
            if (ctrlTready) begin
                void'(expQ.pop_front());
                void'(lastQ.pop_front());
            end
            @(negedge clock);
            cyc++;
            budget--;
        end
        if (expQ.size() > 0) begin
            checkOutput({tag, "_beats_left"}, 160'(expQ.size()), 160'(0));
            expQ.delete();
            lastQ.delete();
        end
        ctrlTready = 1'b0;
    endtask

    task automatic runFrameAndEof(input string tag, input int w, input int h, input int mode, input int wpb, input int bps);
        applyStimulus(1'b0, w, h);
        checkOutput({tag, "_no_eof_ready_in_ip"}, 160'(obsEofReady), 160'(0));
        loadIpPacket(w, h, wpb, bps);
        drainPacket({tag, "_ip"}, mode);
        checkOutput({tag, "_eof_ready_after_ip"}, 160'(obsEofReady), 160'(1));
        checkOutput({tag, "_frame_ready_in_frame"}, 160'(obsFrameReady), 160'(0));
        applyStimulus(1'b1, w, h);
        loadEofPacket();
        drainPacket({tag, "_eof"}, mode);
        checkOutput({tag, "_idle_frame_ready"}, 160'(obsFrameReady), 160'(1));
        checkOutput({tag, "_idle_tvalid"}, 160'(obsValid), 160'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("rst_tvalid", 160'(aValid), 160'(0));
        checkOutput("rst_tlast", 160'(aLast), 160'(0));
        checkOutput("rst_tuser", 160'(aUser), 160'(0));
        checkOutput("rst_tdata", 160'(aData), 160'(0));
        checkOutput("rst_frame_ready", 160'(aFrameReady), 160'(1));
        checkOutput("rst_eof_ready", 160'(aEofReady), 160'(0));
        checkOutput("rst_b_tvalid", 160'(bValid), 160'(0));
        reset = 1'b0;
        @(negedge clock);

        // Directed 1920x1080, full-rate then stalled every other cycle
        runFrameAndEof("hd_ready", 1920, 1080, 0, A_WPB, A_BPS);
        runFrameAndEof("hd_stall", 1920, 1080, 1, A_WPB, A_BPS);

        // Saturated width and zero height
        runFrameAndEof("sat", 5000, 0, 0, A_WPB, A_BPS);
        runFrameAndEof("sat_max", 4096, 2161, 2, A_WPB, A_BPS);

        // Frame and EOF together in IDLE; second frame held off until EOF completes
        aEofValid = 1'b1;
        applyStimulus(1'b0, 640, 480);
        checkOutput("both_no_eof_ready", 160'(aEofReady), 160'(0));
        loadIpPacket(640, 480, A_WPB, A_BPS);
        drainPacket("both_ip", 0);
        checkOutput("both_eof_ready", 160'(aEofReady), 160'(1));
        applyStimulus(1'b1, 640, 480);
        aFrameValid = 1'b1;
        checkOutput("both_frame_held", 160'(aFrameReady), 160'(0));
        loadEofPacket();
        drainPacket("both_eof", 0);
        applyStimulus(1'b0, 320, 240);
        loadIpPacket(320, 240, A_WPB, A_BPS);
        drainPacket("both_ip2", 0);
        applyStimulus(1'b1, 0, 0);
        loadEofPacket();
        drainPacket("both_eof2", 0);

        // Asynchronous reset while the third IP beat is on the bus
        applyStimulus(1'b0, 1280, 720);
        loadIpPacket(1280, 720, A_WPB, A_BPS);
        for (int i = 0; i < 2; i++) begin
            ctrlTready = 1'b1;
            checkOutput("rst_mid_pre_tdata", 160'(aData), expQ[0]);
            void'(expQ.pop_front());
            void'(lastQ.pop_front());
            @(negedge clock);
        end
        ctrlTready = 1'b0;
        checkOutput("rst_mid_beat2_valid", 160'(aValid), 160'(1));
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_tvalid", 160'(aValid), 160'(0));
        checkOutput("rst_mid_tlast", 160'(aLast), 160'(0));
        checkOutput("rst_mid_frame_ready", 160'(aFrameReady), 160'(1));
        #1 reset = 1'b0;
        expQ.delete();
        lastQ.delete();
        @(negedge clock);
        runFrameAndEof("after_rst", 1280, 720, 0, A_WPB, A_BPS);

        // Randomized frames: sizes spanning zero, in-range and above the limits, random backpressure
        for (int n = 0; n < 10; n++) begin
            int w, h, sel;
            sel = $urandom_range(0, 3);
            w = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(MAX_W + 1, 65535) : $urandom_range(1, MAX_W);
            sel = $urandom_range(0, 3);
            h = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(MAX_H + 1, 65535) : $urandom_range(1, MAX_H);
            runFrameAndEof("rand", w, h, $urandom_range(0, 2), A_WPB, A_BPS);
        end

        // Wide instance: whole IP packet in a single beat with zero padding
        useB = 1'b1;
        runFrameAndEof("wide", 3840, 2160, 0, B_WPB, B_BPS);
        runFrameAndEof("wide_rand", $urandom_range(0, 65535), $urandom_range(0, 65535), 2, B_WPB, B_BPS);
        useB = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
